// File: rtl/ddr3_rw_arbiter.sv
// Shares one Avalon-MM DDR3 port between the camera frame writer and the VGA frame reader.
// Tie-break defaults to round-robin; define ARB_RD_PRIORITY_EN to let reads win every tie.
module ddr3_rw_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int SIZE_W = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_req,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [SIZE_W-1:0]   wr_size,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                wr_data_rd,
   output logic                wr_done,
   input  logic                rd_req,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [SIZE_W-1:0]   rd_size,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_data_valid,
   output logic                rd_done,
   output logic                busy,
   input  logic                avl_waitrequest,
   input  logic                avl_rdata_valid,
   input  logic [DATA_W-1:0]   avl_rdata,
   output logic [ADDR_W-1:0]   avl_addr,
   output logic [SIZE_W-1:0]   avl_size,
   output logic [DATA_W-1:0]   avl_wdata,
   output logic [DATA_W/8-1:0] avl_be,
   output logic                avl_read_req,
   output logic                avl_write_req
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_BURST = 3'd1;
   localparam logic [2:0] RD_CMD   = 3'd2;
   localparam logic [2:0] RD_WAIT  = 3'd3;
   localparam logic [2:0] GAP      = 3'd4;

   logic [2:0]        state;
   logic [SIZE_W-1:0] beat_cnt;
   logic              tie_rd;
   logic              grant_rd;
   logic              grant_wr;
   logic              wr_accept;
   logic              rd_beat;

`ifdef ARB_RD_PRIORITY_EN
   assign tie_rd = 1'b1;
`else
   // Set when the most recent grant went to the writer, so the next tie goes to the reader.
   logic last_grant_wr;
   assign tie_rd = last_grant_wr;
`endif

   assign grant_rd  = rd_req & (~wr_req | tie_rd);
   assign grant_wr  = wr_req & ~grant_rd;

   assign avl_write_req = (state == WR_BURST);
   assign avl_read_req  = (state == RD_CMD);
   assign wr_accept     = avl_write_req & ~avl_waitrequest;
   assign wr_data_rd    = wr_accept;
   assign avl_wdata     = avl_write_req ? wr_data : '0;
   assign avl_be        = {(DATA_W/8){avl_write_req}};
   assign busy          = (state != IDLE);
   assign rd_beat       = ((state == RD_CMD) || (state == RD_WAIT)) & avl_rdata_valid;

   // Read beats are counted in RD_CMD too, so the beat handling below overrides the RD_CMD exit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         beat_cnt      <= '0;
         avl_addr      <= '0;
         avl_size      <= '0;
         wr_done       <= 1'b0;
         rd_done       <= 1'b0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
`ifndef ARB_RD_PRIORITY_EN
         last_grant_wr <= 1'b1;
`endif
      end else begin
         wr_done       <= 1'b0;
         rd_done       <= 1'b0;
         rd_data_valid <= rd_beat;
         if (rd_beat) begin
            rd_data <= avl_rdata;
         end
         case (state)
            IDLE: begin
               if (grant_rd) begin
`ifndef ARB_RD_PRIORITY_EN
                  last_grant_wr <= 1'b0;
`endif
                  if (rd_size == '0) begin
                     rd_done <= 1'b1;
                     state   <= GAP;
                  end else begin
                     avl_addr <= rd_addr;
                     avl_size <= rd_size;
                     beat_cnt <= rd_size;
                     state    <= RD_CMD;
                  end
               end else if (grant_wr) begin
`ifndef ARB_RD_PRIORITY_EN
                  last_grant_wr <= 1'b1;
`endif
                  if (wr_size == '0) begin
                     wr_done <= 1'b1;
                     state   <= GAP;
                  end else begin
                     avl_addr <= wr_addr;
                     avl_size <= wr_size;
                     beat_cnt <= wr_size;
                     state    <= WR_BURST;
                  end
               end
            end
            WR_BURST: begin
               if (wr_accept) begin
                  beat_cnt <= beat_cnt - 1'b1;
                  if (beat_cnt == SIZE_W'(1)) begin
                     wr_done <= 1'b1;
                     state   <= GAP;
                  end
               end
            end
            RD_CMD: begin
               if (!avl_waitrequest) begin
                  state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               state <= RD_WAIT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (rd_beat && (beat_cnt != '0)) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == SIZE_W'(1)) begin
               rd_done <= 1'b1;
               state   <= GAP;
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Self-checking bench for ddr3_rw_arbiter: scoreboard queues hold expected beats and grant order.
module tb_ddr3_rw_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;
   localparam int SIZE_W = 10;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                wr_req;
   logic [ADDR_W-1:0]   wr_addr;
   logic [SIZE_W-1:0]   wr_size;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_data_rd;
   logic                wr_done;
   logic                rd_req;
   logic [ADDR_W-1:0]   rd_addr;
   logic [SIZE_W-1:0]   rd_size;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_data_valid;
   logic                rd_done;
   logic                busy;
   logic                avl_waitrequest;
   logic                avl_rdata_valid;
   logic [DATA_W-1:0]   avl_rdata;
   logic [ADDR_W-1:0]   avl_addr;
   logic [SIZE_W-1:0]   avl_size;
   logic [DATA_W-1:0]   avl_wdata;
   logic [DATA_W/8-1:0] avl_be;
   logic                avl_read_req;
   logic                avl_write_req;

   int vectors = 0;
   int miscompares = 0;

   ddr3_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
      .wr_data_rd(wr_data_rd), .wr_done(wr_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .rd_done(rd_done), .busy(busy),
      .avl_waitrequest(avl_waitrequest), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
      .avl_addr(avl_addr), .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_be(avl_be),
      .avl_read_req(avl_read_req), .avl_write_req(avl_write_req)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_req = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0; rd_size = '0;
      avl_waitrequest = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, avl_write_req, avl_read_req, wr_done, rd_done, rd_data_valid, wr_data_rd} !== 7'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                  {busy, avl_write_req, avl_read_req, wr_done, rd_done, rd_data_valid, wr_data_rd});
      end
      vectors++;
      if ({avl_addr, avl_size, avl_be} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_bus: addr %0h size %0d be %0h expected all 0", avl_addr, avl_size, avl_be);
      end
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({busy, avl_write_req, avl_read_req, wr_done, rd_done, rd_data_valid} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: cycle %0d got %b expected 000000", i,
                     {busy, avl_write_req, avl_read_req, wr_done, rd_done, rd_data_valid});
         end
         next_cycle();
      end
   endtask

   task automatic test_write(input logic with_stall);
      logic [DATA_W-1:0] fifo[$];
      logic [DATA_W-1:0] exp_q[$];
      logic [DATA_W-1:0] exp;
      int stalls[4];
      int beats, wcycles, stall_left;
      logic last_prev, done_seen;
      for (int i = 0; i < 4; i++) begin
         exp = {$urandom, $urandom, $urandom, $urandom};
         fifo.push_back(exp);
         exp_q.push_back(exp);
      end
      stalls[0] = 0; stalls[3] = 0;
      stalls[1] = with_stall ? 2 : 0;
      stalls[2] = with_stall ? 2 : 0;
      wr_req = 1'b1; wr_addr = 32'h100; wr_size = 10'd4; wr_data = fifo[0]; avl_waitrequest = 1'b0;
      @(negedge clk);
      vectors++;
      if (avl_write_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_grant_early: avl_write_req %b expected 0", avl_write_req);
      end
      beats = 0; wcycles = 0; stall_left = stalls[0]; last_prev = 1'b0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
         next_cycle();
         avl_waitrequest = (stall_left > 0);
         wr_data = (fifo.size() > 0) ? fifo[0] : '0;
         @(negedge clk);
         if (cyc == 0) begin
            vectors++;
            if (avl_write_req !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL wr_grant_latency: avl_write_req %b expected 1", avl_write_req);
            end
         end
         vectors++;
         if (wr_done !== last_prev) begin
            miscompares++;
            $display("[TB] FAIL wr_done_timing: cycle %0d got %b expected %b", cyc, wr_done, last_prev);
         end
         done_seen = wr_done;
         last_prev = 1'b0;
         if (avl_write_req) begin
            wcycles++;
            vectors++;
            if (avl_addr !== 32'h100 || avl_size !== 10'd4 || avl_be !== '1) begin
               miscompares++;
               $display("[TB] FAIL wr_cmd: addr %0h size %0d be %0h expected 100 4 ffff", avl_addr, avl_size, avl_be);
            end
            vectors++;
            if (wr_data_rd !== !avl_waitrequest) begin
               miscompares++;
               $display("[TB] FAIL wr_data_rd: got %b expected %b", wr_data_rd, !avl_waitrequest);
            end
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("[TB] FAIL wr_extra_beat: avl_write_req 1 expected 0 after 4 beats");
            end else begin
               vectors++;
               if (avl_wdata !== exp_q[0]) begin
                  miscompares++;
                  $display("[TB] FAIL wr_wdata: beat %0d got %h expected %h", beats, avl_wdata, exp_q[0]);
               end
               if (!avl_waitrequest) begin
                  void'(exp_q.pop_front());
                  void'(fifo.pop_front());
                  beats++;
                  last_prev = (beats == 4);
                  stall_left = (beats < 4) ? stalls[beats] : 0;
               end else begin
                  stall_left--;
               end
            end
         end else begin
            vectors++;
            if (wr_data_rd !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL wr_data_rd_idle: got %b expected 0", wr_data_rd);
            end
         end
      end
      vectors++;
      if (!done_seen || beats != 4 || wcycles != (with_stall ? 8 : 4)) begin
         miscompares++;
         $display("[TB] FAIL wr_burst_summary: done %b beats %0d cycles %0d expected 1 4 %0d",
                  done_seen, beats, wcycles, with_stall ? 8 : 4);
      end
      next_cycle();
      wr_req = 1'b0; avl_waitrequest = 1'b0;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_back_to_idle: busy %b expected 0", busy);
         end
         next_cycle();
      end
   endtask

   task automatic test_read();
      logic              exp_v[$];
      logic [DATA_W-1:0] exp_d[$];
      logic              ev;
      logic [DATA_W-1:0] ed;
      int sent, got;
      logic done_seen;
      rd_req = 1'b1; rd_addr = 32'h2000; rd_size = 10'd8; avl_waitrequest = 1'b0;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      vectors++;
      if (avl_read_req !== 1'b1 || avl_addr !== 32'h2000 || avl_size !== 10'd8) begin
         miscompares++;
         $display("[TB] FAIL rd_cmd: req %b addr %0h size %0d expected 1 2000 8", avl_read_req, avl_addr, avl_size);
      end
      exp_v.push_back(1'b0); exp_d.push_back('0);
      sent = 0; got = 0; done_seen = 1'b0;
      for (int k = 0; k < 40 && !done_seen; k++) begin
         next_cycle();
         avl_rdata_valid = ((k % 3) != 2) && (sent < 8);
         avl_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (avl_rdata_valid) sent++;
         exp_v.push_back(avl_rdata_valid); exp_d.push_back(avl_rdata);
         @(negedge clk);
         if (k == 0) begin
            vectors++;
            if (avl_read_req !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL rd_cmd_drop: avl_read_req %b expected 0", avl_read_req);
            end
         end
         ev = exp_v.pop_front(); ed = exp_d.pop_front();
         if (ev) got++;
         vectors++;
         if (rd_data_valid !== ev || (ev && rd_data !== ed)) begin
            miscompares++;
            $display("[TB] FAIL rd_beat: k %0d valid %b data %h expected %b %h", k, rd_data_valid, rd_data, ev, ed);
         end
         vectors++;
         if (rd_done !== (ev && got == 8)) begin
            miscompares++;
            $display("[TB] FAIL rd_done_timing: k %0d got %b expected %b", k, rd_done, ev && got == 8);
         end
         done_seen = rd_done;
      end
      vectors++;
      if (!done_seen || got != 8) begin
         miscompares++;
         $display("[TB] FAIL rd_burst_summary: done %b beats %0d expected 1 8", done_seen, got);
      end
      next_cycle();
      rd_req = 1'b0; avl_rdata_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rd_back_to_idle: busy %b expected 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_zero_size();
      wr_req = 1'b1; wr_addr = 32'h500; wr_size = '0;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({wr_done, busy, avl_write_req, wr_data_rd} !== 4'b1100) begin
         miscompares++;
         $display("[TB] FAIL zero_size_done: done,busy,wreq,pop %b expected 1100",
                  {wr_done, busy, avl_write_req, wr_data_rd});
      end
      next_cycle();
      wr_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({wr_done, busy, avl_write_req} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL zero_size_after: done,busy,wreq %b expected 000", {wr_done, busy, avl_write_req});
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic exp_rd[$];
      logic e;
      int grants, dones, sent;
      logic rd_active, wr_prev, finished;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_RD_PRIORITY_EN
         exp_rd.push_back(1'b1);
`else
         exp_rd.push_back((i % 2) == 0);
`endif
      end
      grants = 0; dones = 0; sent = 0; rd_active = 1'b0; wr_prev = 1'b0; finished = 1'b0;
      wr_addr = 32'h4000; wr_size = 10'd2; rd_addr = 32'h8000; rd_size = 10'd2; avl_waitrequest = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         wr_req = 1'b1; rd_req = 1'b1;
         wr_data = {$urandom, $urandom, $urandom, $urandom};
         avl_rdata_valid = rd_active && (sent < 2);
         avl_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (avl_rdata_valid) sent++;
         @(negedge clk);
         if (avl_read_req || (avl_write_req && !wr_prev)) begin
            if (exp_rd.size() == 0) begin
               vectors++; miscompares++;
               $display("[TB] FAIL tie_extra_grant: read %b expected no grant", avl_read_req);
            end else begin
               e = exp_rd.pop_front();
               vectors++;
               if (avl_read_req !== e) begin
                  miscompares++;
                  $display("[TB] FAIL tie_order: grant %0d read %b expected %b", grants, avl_read_req, e);
               end
            end
            grants++;
            if (avl_read_req) begin
               rd_active = 1'b1;
               sent = 0;
            end
         end
         wr_prev = avl_write_req;
         if (rd_done || wr_done) begin
            dones++;
            rd_active = 1'b0;
            finished = (dones == 4);
         end
         next_cycle();
      end
      wr_req = 1'b0; rd_req = 1'b0; avl_rdata_valid = 1'b0;
      vectors++;
      if (grants != 4 || dones != 4) begin
         miscompares++;
         $display("[TB] FAIL tie_summary: grants %0d dones %0d expected 4 4", grants, dones);
      end
      repeat (2) begin
         @(negedge clk);
         next_cycle();
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL tie_back_to_idle: busy %b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_read();
      rd_req = 1'b1; rd_addr = 32'h3000; rd_size = 10'd8; avl_waitrequest = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         avl_rdata_valid = 1'b1;
         avl_rdata = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      @(posedge clk);
      #3;
      vectors++;
      if ({busy, rd_data_valid, rd_done} !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL mid_read_precond: busy,valid,done %b expected 110", {busy, rd_data_valid, rd_done});
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, rd_data_valid, rd_done, avl_read_req} !== 4'b0 || avl_addr !== '0 || avl_size !== '0 || rd_data !== '0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: busy,valid,done,rreq %b addr %0h size %0d expected all 0",
                  {busy, rd_data_valid, rd_done, avl_read_req}, avl_addr, avl_size);
      end
      rd_req = 1'b0; avl_rdata_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            next_cycle();
            rst_n = 1'b1;
         end
         @(negedge clk);
         vectors++;
         if ({busy, rd_done, rd_data_valid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_abandon: cycle %0d busy,done,valid %b expected 000", i,
                     {busy, rd_done, rd_data_valid});
         end
      end
   endtask

   initial begin
      test_reset();
      test_write(1'b0);
      test_write(1'b1);
      test_read();
      test_zero_size();
      test_back_to_back();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
